// File: rtl/run_control_pkg.sv
// rtl/run_control_pkg.sv - shared run-control constants: host opcodes, halt causes, FSM states
package run_control_pkg;

  typedef enum logic [2:0] {
    OP_RUN     = 3'd0,
    OP_HALT    = 3'd1,
    OP_STEP    = 3'd2,
    OP_SET_BP  = 3'd3,
    OP_CLR_BP  = 3'd4,
    OP_CLR_CNT = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HOST = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_STEP = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

  // A STEP argument of zero still executes one instruction.
  function automatic logic [31:0] step_load_value(input logic [31:0] arg);
    return (arg == 32'd0) ? 32'd1 : arg;
  endfunction

endpackage

// File: rtl/run_counter.sv
// rtl/run_counter.sv - step down-counter and retired-instruction up-counter
// Ports: clk, reset (sync, active-high); step_load/step_val load the step count,
// step_dec decrements it; ret_inc increments retired (wraps), ret_clr zeroes it
// and wins over a coincident increment; step_cnt, retired are the register values.
module run_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_load,
  input  logic [31:0] step_val,
  input  logic        step_dec,
  input  logic        ret_inc,
  input  logic        ret_clr,
  output logic [31:0] step_cnt,
  output logic [31:0] retired
);

  logic [31:0] step_q;
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q    <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      if (step_load) begin
        step_q <= step_val;
      end else if (step_dec) begin
        step_q <= step_q - 32'd1;
      end
      if (ret_clr) begin
        retired_q <= 32'd0;
      end else if (ret_inc) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign step_cnt = step_q;
  assign retired  = retired_q;

endmodule

// File: rtl/run_control.sv
// rtl/run_control.sv - processor run/halt/step controller with one PC breakpoint
// Ports: clk, reset (sync, active-high); host command channel cmd_valid/cmd_ready/
// cmd_op/cmd_arg with cmd_err pulse; pc in; cpu_en execution gate; halted,
// halt_cause status; retired count of enabled cycles.
module run_control
  import run_control_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired,
  output logic        cmd_err
);

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic        skip_q, skip_d;
  logic        bp_en_q, bp_en_d;
  logic [31:0] bp_addr_q, bp_addr_d;
  logic        err_q, err_d;

  logic        acc;
  logic        bp_hit;
  logic        step_load;
  logic        step_dec;
  logic        ret_clr;
  logic [31:0] step_cnt;

  assign cmd_ready = !reset;
  assign acc       = cmd_valid && cmd_ready;
  // skip_bp lets the instruction sitting on the breakpoint execute once after resume.
  assign bp_hit    = bp_en_q && (pc == bp_addr_q) && !skip_q;
  assign cpu_en    = (state_q != ST_HALTED) && !bp_hit;
  assign halted    = (state_q == ST_HALTED);
  assign halt_cause = cause_q;
  assign cmd_err   = err_q;

  assign step_dec = (state_q == ST_STEPPING) && cpu_en;
  assign ret_clr  = acc && (cmd_op == OP_CLR_CNT);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    skip_d    = skip_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    err_d     = 1'b0;
    step_load = 1'b0;

    if (cpu_en) begin
      skip_d = 1'b0;
    end

    if (acc) begin
      case (cmd_op)
        OP_RUN: begin
          if (state_q == ST_HALTED) begin
            state_d = ST_RUNNING;
            skip_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STEP: begin
          if (state_q == ST_HALTED) begin
            state_d   = ST_STEPPING;
            skip_d    = 1'b1;
            step_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_SET_BP: begin
          bp_en_d   = 1'b1;
          bp_addr_d = cmd_arg;
        end
        OP_CLR_BP:  bp_en_d = 1'b0;
        OP_HALT:    ;
        OP_CLR_CNT: ;
        default:    err_d = 1'b1;
      endcase
    end

    // Halt conditions only arise while executing; ordering encodes HOST > BP > STEP.
    if (state_q != ST_HALTED) begin
      if (acc && (cmd_op == OP_HALT)) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_HOST;
      end else if (bp_hit) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_BP;
      end else if ((state_q == ST_STEPPING) && cpu_en && (step_cnt == 32'd1)) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN_ON_RESET ? ST_RUNNING : ST_HALTED;
      cause_q   <= CAUSE_NONE;
      skip_q    <= 1'b0;
      bp_en_q   <= 1'b0;
      bp_addr_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      skip_q    <= skip_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      err_q     <= err_d;
    end
  end

  run_counter u_counter (
    .clk       (clk),
    .reset     (reset),
    .step_load (step_load),
    .step_val  (step_load_value(cmd_arg)),
    .step_dec  (step_dec),
    .ret_inc   (cpu_en),
    .ret_clr   (ret_clr),
    .step_cnt  (step_cnt),
    .retired   (retired)
  );

endmodule

// File: tb/tb_run_control.sv
// tb/tb_run_control.sv - directed scoreboard bench for run_control
module tb_run_control;
  import run_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] retired;
  logic        cmd_err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic loop_en = 1'b0;

  always #5 clk = ~clk;

  run_control #(.RUN_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .halt_cause (halt_cause),
    .retired    (retired),
    .cmd_err    (cmd_err)
  );

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock: cpu_en sampled mid-cycle, the modelled CPU advances its PC only
  // when enabled; returns at posedge+2 with outputs settled.
  task automatic tick();
    logic en;
    @(negedge clk);
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en === 1'b1 && !reset) pc = (loop_en && pc == 32'h18) ? 32'h10 : pc + 32'd4;
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0; pc = 32'd0;

    // reset state
    expect_val("rst_cmd_ready", 0);
    expect_val("rst_retired", 0);
    expect_val("rst_halted", 0);
    expect_val("rst_cause", CAUSE_NONE);
    expect_val("rst_cmd_err", 0);
    tick(); tick();
    chk(cmd_ready); chk(retired); chk(halted); chk(halt_cause); chk(cmd_err);

    // free run for 8 cycles
    reset = 1'b0;
    expect_val("run8_cmd_ready", 1);
    #1 chk(cmd_ready);
    expect_val("run8_en_cycles", 8);
    expect_val("run8_retired", 8);
    expect_val("run8_cause", CAUSE_NONE);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1 if (cpu_en === 1'b1) n++;
      tick();
    end
    chk(n); chk(retired); chk(halt_cause);

    // breakpoint at 0x10 while running from PC 0
    reset = 1'b1; tick(); reset = 1'b0; pc = 32'd0;
    expect_val("bp_en_low_at_10", 0);
    expect_val("bp_halted", 1);
    expect_val("bp_cause", CAUSE_BP);
    expect_val("bp_retired", 4);
    cmd(OP_SET_BP, 32'h10);
    tick(); tick(); tick();
    chk(cpu_en);
    tick();
    chk(halted); chk(halt_cause); chk(retired);

    // HALT while halted leaves cause alone
    expect_val("halt_noop_cause", CAUSE_BP);
    expect_val("halt_noop_halted", 1);
    cmd(OP_HALT, 0);
    chk(halt_cause); chk(halted);

    // resume executes the breakpointed instruction, loop returns and re-halts
    loop_en = 1'b1;
    expect_val("resume_halted", 0);
    expect_val("resume_en", 1);
    expect_val("resume_no_rehalt", 0);
    expect_val("loop_en_low", 0);
    expect_val("loop_halted", 1);
    expect_val("loop_cause", CAUSE_BP);
    expect_val("loop_retired", 7);
    cmd(OP_RUN, 0);
    chk(halted); chk(cpu_en);
    tick();
    chk(halted);
    tick(); tick();
    chk(cpu_en);
    tick();
    chk(halted); chk(halt_cause); chk(retired);

    // STEP 3 then STEP 0
    cmd(OP_CLR_BP, 0);
    expect_val("step3_cycles", 3);
    expect_val("step3_halted", 1);
    expect_val("step3_cause", CAUSE_STEP);
    expect_val("step3_retired", 10);
    cmd(OP_STEP, 32'd3);
    n = 0;
    for (int i = 0; i < 10 && halted !== 1'b1; i++) begin
      if (cpu_en === 1'b1) n++;
      tick();
    end
    chk(n); chk(halted); chk(halt_cause); chk(retired);

    expect_val("step0_cycles", 1);
    expect_val("step0_halted", 1);
    expect_val("step0_retired", 11);
    cmd(OP_STEP, 32'd0);
    n = 0;
    for (int i = 0; i < 10 && halted !== 1'b1; i++) begin
      if (cpu_en === 1'b1) n++;
      tick();
    end
    chk(n); chk(halted); chk(retired);

    // HOST halt coinciding with the last step decrement
    expect_val("prio_halted", 1);
    expect_val("prio_cause", CAUSE_HOST);
    expect_val("prio_retired", 13);
    cmd(OP_STEP, 32'd2);
    tick();
    cmd(OP_HALT, 0);
    chk(halted); chk(halt_cause); chk(retired);

    // discarded commands pulse cmd_err for one cycle
    cmd(OP_RUN, 0);
    expect_val("run_running_err", 1);
    expect_val("run_running_state", 0);
    expect_val("run_running_err_clear", 0);
    cmd(OP_RUN, 0);
    chk(cmd_err); chk(halted);
    tick();
    chk(cmd_err);
    expect_val("op7_err", 1);
    expect_val("op7_state", 0);
    expect_val("op7_err_clear", 0);
    cmd(3'd7, 0);
    chk(cmd_err); chk(halted);
    tick();
    chk(cmd_err);

    // CLR_CNT while running wins over the increment, then counting resumes
    expect_val("clr_cnt_zero", 0);
    expect_val("clr_cnt_resume", 1);
    cmd(OP_CLR_CNT, 0);
    chk(retired);
    tick();
    chk(retired);

    // reset overrides a command in the same cycle
    expect_val("rst_ovr_ready", 0);
    expect_val("rst_ovr_err", 0);
    expect_val("rst_ovr_retired", 0);
    expect_val("rst_ovr_halted", 0);
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd7;
    #1 chk(cmd_ready);
    tick();
    cmd_valid = 1'b0; reset = 1'b0;
    chk(cmd_err); chk(retired); chk(halted);

    // retired wraps from all ones
    cmd(OP_HALT, 0);
    force dut.u_counter.retired_q = 32'hFFFF_FFFF;
    #1 release dut.u_counter.retired_q;
    expect_val("wrap_preset", 32'hFFFF_FFFF);
    expect_val("wrap_zero", 0);
    expect_val("wrap_cause", CAUSE_STEP);
    #1 chk(retired);
    cmd(OP_STEP, 32'd1);
    tick();
    chk(retired); chk(halt_cause);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
